load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's memory stage and synchronous_data_memory, driving its addr/write_data/write_enable and consuming synchronous_read_data.
- Turns byte, halfword and word loads/stores into word-wide memory accesses.
- Performs read-modify-write for sub-word stores and sign- or zero-extension for loads.
- Flags misaligned or out-of-range accesses without touching memory.

Parameters:
- MEM_WORDS, 4096: number of 32-bit words in the attached memory. Word index >= MEM_WORDS is a fault.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  access request; core holds req/we/size/unsigned_ld/addr/wdata stable until done
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word, 11 reserved
- unsigned_ld  in  1  1 = zero-extend load, 0 = sign-extend
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned for byte/half
- rdata  out  32  registered load result
- done  out  1  one-cycle completion pulse
- err  out  1  registered fault flag, valid with done
- busy  out  1  state != IDLE
- mem_addr  out  32  word index = latched addr[31:2], zero-extended
- mem_wdata  out  32  word to write
- mem_we  out  1  memory write enable
- mem_rdata  in  32  memory synchronous read data

Behaviour:
- Reset (async): state=IDLE, rdata=0, done=0, err=0. In IDLE, mem_we=0, mem_addr=0, mem_wdata=0. All memory-side outputs are combinational from state and the latched request.
- Accept: req=1 in IDLE at a rising edge latches addr, wdata, size, we and unsigned_ld, and clears err. req while busy=1 is ignored.
- Fault check at accept: size=11, half with addr[0]=1, word with addr[1:0]!=0, or addr[31:2]>=MEM_WORDS.
  - Stay IDLE; next cycle done=1, err=1.
  - rdata unchanged; mem_we never asserted.
- States: IDLE, WR, RD, RD_CAP, RMW_RD, RMW_WR.
- Word store: IDLE->WR. In WR: mem_we=1, mem_wdata=wdata. Next edge writes memory, ->IDLE, done=1. done appears 2 edges after accept.
- Load: IDLE->RD (mem_we=0, mem_addr valid) ->RD_CAP (mem_rdata valid).
  - Next edge: rdata<=extracted value, done=1, ->IDLE. done appears 3 edges after accept.
- Sub-word store: IDLE->RMW_RD (read issued) ->RMW_WR.
  - In RMW_WR: mem_we=1, mem_wdata = mem_rdata with the selected lane(s) replaced.
  - Next edge writes, ->IDLE, done=1. done appears 3 edges after accept.
- Lanes are little-endian: byte k = bits [8k+7:8k], k=addr[1:0]. Half at addr[1]=0 is [15:0]; at addr[1]=1 it is [31:16].
- Extension: byte/half sign-extend from bit 7/15 when unsigned_ld=0, else zero-extend. Word loads pass through.
- mem_addr holds the latched word index in every non-IDLE state.
- done is high exactly one cycle per accepted request. A new req may be accepted in the same cycle done is high (state is IDLE).
- Reset mid-operation: state returns to IDLE immediately and mem_we drops. Reset asserted before the RMW_WR/WR edge leaves memory unmodified; no done is issued.

Test Plan:
- Word store addr=0x10, wdata=0xDEADBEEF, then word load addr=0x10 -> mem[4]=0xDEADBEEF; load done 3 edges after accept; rdata=0xDEADBEEF, err=0.
- mem[4]=0x11223344; byte store addr=0x12, wdata=0xAA -> mem[4]=0x11AA3344, with exactly one mem_we cycle, in RMW_WR.
- mem[4]=0x80FF7F01:
  - signed byte load addr=0x13 -> rdata=0xFFFFFF80.
  - unsigned byte load addr=0x13 -> rdata=0x00000080.
  - signed half load addr=0x10 -> rdata=0x00007F01.
- Word load addr=0x11 -> done+err next cycle, mem_we never asserted, rdata unchanged. Word load addr=4*MEM_WORDS -> err=1.
- Half store addr=0x12, wdata=0xBEEF over mem[4]=0x11223344; assert rst during RMW_WR before the edge -> mem[4]=0x11223344, done=0, busy=0, rdata=0.
- Back-to-back: assert req with a new load in the cycle done=1 -> second request accepted that edge, two separate done pulses.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: maps byte/half/word accesses onto a word-wide synchronous memory,
// with read-modify-write for sub-word stores and sign/zero extension for loads.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned_ld,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_err,
  output logic        o_busy,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_we,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR     = 3'd1;
  localparam logic [2:0] S_RD     = 3'd2;
  localparam logic [2:0] S_RD_CAP = 3'd3;
  localparam logic [2:0] S_RMW_RD = 3'd4;
  localparam logic [2:0] S_RMW_WR = 3'd5;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_rdata;
  logic        r_done;
  logic        r_err;

  logic        w_accept;
  logic        w_fault;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_val;
  logic [31:0] w_merge;

  assign w_accept = i_req && (r_state == S_IDLE);
  assign w_fault  = (i_size == 2'b11)
                 || ((i_size == SZ_HALF) && i_addr[0])
                 || ((i_size == SZ_WORD) && (i_addr[1:0] != 2'b00))
                 || ({2'b00, i_addr[31:2]} >= 32'(MEM_WORDS));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_fault) begin
          if (!i_we)                 w_state_nxt = S_RD;
          else if (i_size == SZ_WORD) w_state_nxt = S_WR;
          else                       w_state_nxt = S_RMW_RD;
        end
      end
      S_WR:     w_state_nxt = S_IDLE;
      S_RD:     w_state_nxt = S_RD_CAP;
      S_RD_CAP: w_state_nxt = S_IDLE;
      S_RMW_RD: w_state_nxt = S_RMW_WR;
      S_RMW_WR: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Little-endian lane selection and extension of the returned word
  always_comb begin
    w_byte = i_mem_rdata[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = i_mem_rdata[7:0];
      2'd1: w_byte = i_mem_rdata[15:8];
      2'd2: w_byte = i_mem_rdata[23:16];
      2'd3: w_byte = i_mem_rdata[31:24];
      default: w_byte = i_mem_rdata[7:0];
    endcase
    w_half = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (r_size)
      SZ_BYTE: w_load_val = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: w_load_val = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_val = i_mem_rdata;
    endcase
  end

  // Replace the addressed lane(s) of the old word for sub-word stores
  always_comb begin
    w_merge = i_mem_rdata;
    if (r_size == SZ_BYTE) begin
      case (r_addr[1:0])
        2'd0: w_merge[7:0]   = r_wdata[7:0];
        2'd1: w_merge[15:8]  = r_wdata[7:0];
        2'd2: w_merge[23:16] = r_wdata[7:0];
        2'd3: w_merge[31:24] = r_wdata[7:0];
        default: w_merge = i_mem_rdata;
      endcase
    end else if (r_addr[1]) begin
      w_merge[31:16] = r_wdata[15:0];
    end else begin
      w_merge[15:0] = r_wdata[15:0];
    end
  end

  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = 32'd0;
    o_mem_wdata = 32'd0;
    if (r_state != S_IDLE) o_mem_addr = {2'b00, r_addr[31:2]};
    if (r_state == S_WR) begin
      o_mem_we    = 1'b1;
      o_mem_wdata = r_wdata;
    end else if (r_state == S_RMW_WR) begin
      o_mem_we    = 1'b1;
      o_mem_wdata = w_merge;
    end
  end

  // Request latch, completion pulse, fault flag and load result
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_rdata    <= 32'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_addr     <= i_addr;
        r_wdata    <= i_wdata;
        r_size     <= i_size;
        r_unsigned <= i_unsigned_ld;
        r_err      <= w_fault;
        r_done     <= w_fault;
      end
      if ((r_state == S_WR) || (r_state == S_RMW_WR)) r_done <= 1'b1;
      if (r_state == S_RD_CAP) begin
        r_done  <= 1'b1;
        r_rdata <= w_load_val;
      end
    end
  end

  assign o_rdata = r_rdata;
  assign o_done  = r_done;
  assign o_err   = r_err;
  assign o_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: attached synchronous memory, transaction-level reference
// model checked every cycle, plus directed vectors with hand-computed results.
module tb_load_store_unit;

  localparam int unsigned MEM_WORDS = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_size(size),
    .i_unsigned_ld(uns), .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata), .o_done(done), .o_err(err), .o_busy(busy),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Attached synchronous memory with a bench-side preload port
  logic [31:0] mem [0:MEM_WORDS-1];
  logic        pk_en = 1'b0;
  logic [11:0] pk_idx = 12'd0;
  logic [31:0] pk_val = 32'd0;
  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr[11:0]] <= mem_wdata;
    else if (pk_en) mem[pk_idx] <= pk_val;
    mem_rdata <= mem[mem_addr[11:0]];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_we = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one record per accepted request, timed in cycles from acceptance
  typedef struct {
    int unsigned c;
    int unsigned lat;
    bit          fault;
    bit          st;
    logic [31:0] addr;
    logic [31:0] wword;
    logic [31:0] rval;
  } rec_t;

  rec_t q[$];
  logic [31:0] mmem [int unsigned];
  logic [31:0] model_rdata = 32'd0;

  always @(negedge clk) begin
    rec_t r;
    logic e_done, e_busy, e_we, e_err;
    logic [31:0] e_maddr, e_wd;
    if (!rst) begin
      if (done)   n_done++;
      if (mem_we) n_we++;
      e_done = 1'b0; e_busy = 1'b0; e_we = 1'b0; e_err = 1'b0;
      e_maddr = 32'd0; e_wd = 32'd0;
      foreach (q[i]) begin
        r = q[i];
        if (cyc == r.c + r.lat) begin
          e_done = 1'b1;
          e_err  = r.fault;
          if (!r.st && !r.fault) model_rdata = r.rval;
        end
        if (!r.fault && cyc >= r.c && cyc < r.c + r.lat) begin
          e_busy  = 1'b1;
          e_maddr = r.addr >> 2;
          if (r.st && cyc == r.c + r.lat - 1) begin
            e_we = 1'b1;
            e_wd = r.wword;
          end
        end
      end
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", mem_addr, e_maddr);
      if (e_we)   chk("mem_wdata", mem_wdata, e_wd);
      if (e_done) chk("err", 32'(err), 32'(e_err));
      chk("rdata", rdata, model_rdata);
      while (q.size() > 0 && cyc >= q[0].c + q[0].lat) void'(q.pop_front());
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic poke(input int unsigned idx, input logic [31:0] v);
    pk_en = 1'b1; pk_idx = 12'(idx); pk_val = v; mmem[idx] = v;
    tick();
    pk_en = 1'b0;
  endtask

  task automatic issue(input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] d, output int unsigned c);
    rec_t r;
    logic [31:0] old, m;
    int unsigned sh;
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    r.c = cyc + 1; r.addr = a; r.st = w;
    r.fault = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
           || (a / 4 >= MEM_WORDS);
    old = mmem.exists(a / 4) ? mmem[a / 4] : 32'd0;
    if (sz == 2'd0)      begin sh = 8 * (a % 4);        m = 32'hFF;   end
    else if (sz == 2'd1) begin sh = 16 * ((a / 2) % 2); m = 32'hFFFF; end
    else                 begin sh = 0;                  m = 32'hFFFF_FFFF; end
    if (r.fault)                   r.lat = 0;
    else if (w && sz == 2'd2)      r.lat = 1;
    else                           r.lat = 2;
    r.rval = (old >> sh) & m;
    if (!u && m != 32'hFFFF_FFFF && (r.rval & ((m >> 1) + 1)) != 0) r.rval = r.rval | ~m;
    r.wword = (old & ~(m << sh)) | ((d & m) << sh);
    if (w && !r.fault) mmem[a / 4] = r.wword;
    q.push_back(r);
    c = r.c;
  endtask

  task automatic wait_done(input bit keep, output int unsigned dc);
    bit seen = 1'b0;
    dc = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (done) begin seen = 1'b1; dc = cyc; end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    if (!keep) req = 1'b0;
  endtask

  // Complete access; returns accept cycle and done cycle
  task automatic access(input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] d,
                        output int unsigned c, output int unsigned dc);
    issue(w, sz, u, a, d, c);
    wait_done(1'b0, dc);
  endtask

  initial begin
    int unsigned c, dc, c2, dc2;
    int we0, dn0;
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned c, dc, c2, dc2;
    int we0, dn0;
    tick(); tick();
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    tick();

    // Word store then word load
    access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, c, dc);
    chk("wst_latency", dc - c, 32'd1);
    chk("wst_mem4", mem[4], 32'hDEADBEEF);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, c, dc);
    chk("wld_latency", dc - c, 32'd2);
    chk("wld_rdata", rdata, 32'hDEADBEEF);
    chk("wld_err", 32'(err), 32'd0);

    // Byte store read-modify-write
    poke(4, 32'h11223344);
    we0 = n_we;
    access(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA, c, dc);
    chk("bst_mem4", mem[4], 32'h11AA3344);
    chk("bst_we_cycles", 32'(n_we - we0), 32'd1);
    chk("bst_latency", dc - c, 32'd2);
    access(1'b1, 2'd0, 1'b0, 32'h10, 32'hFFFFFF55, c, dc);
    chk("bst0_mem4", mem[4], 32'h11AA3355);
    access(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000CAFE, c, dc);
    chk("hst_hi_mem4", mem[4], 32'hCAFE3355);
    access(1'b1, 2'd1, 1'b0, 32'h10, 32'h12349876, c, dc);
    chk("hst_lo_mem4", mem[4], 32'hCAFE9876);

    // Extension
    poke(4, 32'h80FF7F01);
    access(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, c, dc);
    chk("lb_s_13", rdata, 32'hFFFFFF80);
    access(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, c, dc);
    chk("lb_u_13", rdata, 32'h00000080);
    access(1'b0, 2'd1, 1'b0, 32'h10, 32'd0, c, dc);
    chk("lh_s_10", rdata, 32'h00007F01);
    access(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, c, dc);
    chk("lh_s_12", rdata, 32'hFFFF80FF);
    access(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, c, dc);
    chk("lh_u_12", rdata, 32'h000080FF);
    access(1'b0, 2'd0, 1'b0, 32'h11, 32'd0, c, dc);
    chk("lb_s_11", rdata, 32'h0000007F);

    // Faults: no memory write, rdata held
    we0 = n_we;
    access(1'b0, 2'd2, 1'b0, 32'h11, 32'd0, c, dc);
    chk("flt_mis_latency", dc - c, 32'd0);
    chk("flt_mis_err", 32'(err), 32'd1);
    chk("flt_mis_rdata", rdata, 32'h0000007F);
    access(1'b0, 2'd2, 1'b0, 32'(4 * MEM_WORDS), 32'd0, c, dc);
    chk("flt_range_err", 32'(err), 32'd1);
    access(1'b1, 2'd3, 1'b0, 32'h10, 32'h1, c, dc);
    chk("flt_size_err", 32'(err), 32'd1);
    access(1'b1, 2'd1, 1'b0, 32'h11, 32'h1, c, dc);
    chk("flt_half_err", 32'(err), 32'd1);
    chk("flt_no_we", 32'(n_we - we0), 32'd0);
    chk("flt_mem4", mem[4], 32'h80FF7F01);
    access(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, c, dc);
    chk("err_cleared", 32'(err), 32'd0);

    // Reset during RMW_WR, before the writing edge
    poke(4, 32'h11223344);
    dn0 = n_done;
    issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000BEEF, c);
    tick();
    tick();
    chk("abort_in_wr", 32'(mem_we), 32'd1);
    rst = 1'b1;
    req = 1'b0;
    q.delete();
    model_rdata = 32'd0;
    mmem[4] = 32'h11223344;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    tick();
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    chk("abort_mem4", mem[4], 32'h11223344);
    chk("abort_no_done", 32'(n_done - dn0), 32'd0);

    // Back-to-back: second request accepted in the done cycle of the first
    poke(5, 32'h12345678);
    dn0 = n_done;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, c);
    wait_done(1'b1, dc);
    chk("b2b_first_rdata", rdata, 32'h11223344);
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, c2);
    wait_done(1'b0, dc2);
    chk("b2b_gap", dc2 - dc, 32'd3);
    chk("b2b_second_rdata", rdata, 32'h12345678);
    tick(); tick();
    chk("b2b_done_pulses", 32'(n_done - dn0), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
